// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: fetch request/response, instruction handoff and redirect signals
interface fetch_ctrl_if #(
   parameter int unsigned xlen = 32
);
   logic            imem_req_valid;
   logic [xlen-1:0] imem_req_addr;
   logic            imem_req_ready;
   logic            imem_rsp_valid;
   logic [xlen-1:0] imem_rsp_data;
   logic            instr_valide;
   logic [xlen-1:0] instruction;
   logic [xlen-1:0] instr_pc;
   logic            ok_i;
   logic            redirect_valid;
   logic [xlen-1:0] redirect_pc;
   logic            flushing;

   modport master (
      output imem_req_valid, imem_req_addr, instr_valide, instruction, instr_pc, flushing,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, ok_i, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, instr_valide, instruction, instr_pc, flushing,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, ok_i, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: in-order instruction fetch sequencer with two-credit limit and redirect flush
module fetch_ctrl #(
   parameter int unsigned     xlen       = 32,
   parameter logic [xlen-1:0] START_ADDR = '0
) (
   input logic          clk,
   input logic          rst_n,
   fetch_ctrl_if.master bus
);
   typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

   state_t          state_q, state_d;
   logic [xlen-1:0] fetch_pc_q, fetch_pc_d;
   logic [1:0]      outstanding_q, outstanding_d;
   logic [1:0]      discard_q, discard_d;
   logic [1:0]      count_q, count_d;
   logic            rd_q, rd_d, wr_q, wr_d;
   logic            tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
   logic [xlen-1:0] fifo_pc_q [2];
   logic [xlen-1:0] fifo_word_q [2];
   logic [xlen-1:0] tag_q [2];
   logic            req_valid, accept, rsp, drop, push, pop, redirect;

   // Credits cover both in-flight requests and buffered words, so the FIFO can never overflow.
   assign redirect  = bus.redirect_valid;
   assign req_valid = state_q == RUN && ({1'b0, outstanding_q} + {1'b0, count_q}) < 3'd2;
   assign accept    = req_valid && bus.imem_req_ready;
   assign rsp       = bus.imem_rsp_valid && outstanding_q != 2'd0;
   assign drop      = rsp && discard_q != 2'd0;
   assign push      = rsp && discard_q == 2'd0 && !redirect;
   assign pop       = count_q != 2'd0 && bus.ok_i;

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.instr_valide   = count_q != 2'd0;
   assign bus.instruction    = fifo_word_q[rd_q];
   assign bus.instr_pc       = fifo_pc_q[rd_q];
   assign bus.flushing       = state_q == FLUSH;

   // Next state: normal bookkeeping first, then a redirect overrides pointers and stream position.
   always_comb begin
      outstanding_d = outstanding_q + {1'b0, accept} - {1'b0, rsp};
      count_d       = count_q + {1'b0, push} - {1'b0, pop};
      fetch_pc_d    = accept ? fetch_pc_q + xlen'(4) : fetch_pc_q;
      rd_d          = rd_q ^ pop;
      wr_d          = wr_q ^ push;
      tag_rd_d      = tag_rd_q ^ push;
      tag_wr_d      = tag_wr_q ^ accept;
      discard_d     = discard_q - {1'b0, drop};
      state_d       = state_q == FLUSH && discard_d != 2'd0 ? FLUSH : RUN;
      if (redirect) begin
         fetch_pc_d = bus.redirect_pc & ~xlen'(3);
         count_d    = 2'd0;
         rd_d       = 1'b0;
         wr_d       = 1'b0;
         tag_rd_d   = 1'b0;
         tag_wr_d   = 1'b0;
         discard_d  = outstanding_d;
         state_d    = outstanding_d != 2'd0 ? FLUSH : RUN;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q       <= BOOT;
         fetch_pc_q    <= START_ADDR;
         outstanding_q <= 2'd0;
         discard_q     <= 2'd0;
         count_q       <= 2'd0;
         rd_q          <= 1'b0;
         wr_q          <= 1'b0;
         tag_rd_q      <= 1'b0;
         tag_wr_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         count_q       <= count_d;
         rd_q          <= rd_d;
         wr_q          <= wr_d;
         tag_rd_q      <= tag_rd_d;
         tag_wr_q      <= tag_wr_d;
      end
   end

   // Instruction FIFO storage; cleared on reset so the head reads as zero.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         fifo_pc_q   <= '{default: '0};
         fifo_word_q <= '{default: '0};
      end else if (push) begin
         fifo_pc_q[wr_q]   <= tag_q[tag_rd_q];
         fifo_word_q[wr_q] <= bus.imem_rsp_data;
      end
   end

   // PC tag queue: remembers the address of each accepted request until its response returns.
   always_ff @(posedge clk) begin
      if (accept) tag_q[tag_wr_q] <= fetch_pc_q;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst_n) !(push && count_q == 2'd2));
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized bench with a queue-based reference model of the fetch stream
module tb_fetch_ctrl;
   localparam logic [31:0] START = 32'h0;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   fetch_ctrl_if #(.xlen(32)) bus ();
   fetch_ctrl #(.xlen(32), .START_ADDR(START)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {logic [31:0] pc; bit stale;} tag_t;
   typedef struct {logic [31:0] pc; logic [31:0] word;} ent_t;
   typedef struct {logic [31:0] addr; int due;} mreq_t;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   tag_t        tags[$];
   ent_t        fifo[$];
   mreq_t       memq[$];
   logic [31:0] acc_log[$];
   logic [31:0] pop_log[$];
   logic [31:0] m_pc;
   logic [31:0] key;
   bit          m_boot;
   bit          ev_collide;
   int          lat_min, lat_max;

   // One cycle: check outputs against the model, drive inputs, advance model after the edge.
   task automatic step(input bit ready, input bit ok, input int rmode, input logic [31:0] rpc);
      bit          exp_flush, exp_rv, exp_iv, rsp, acc, redir;
      logic [31:0] rdata;
      tag_t        t;
      mreq_t       mq;
      ent_t        e;
      exp_flush = 1'b0;
      foreach (tags[i]) if (tags[i].stale) exp_flush = 1'b1;
      exp_rv = !m_boot && !exp_flush && (tags.size() + fifo.size() < 2);
      exp_iv = fifo.size() != 0;
      tests++;
      if (bus.imem_req_valid !== exp_rv || bus.flushing !== exp_flush || bus.instr_valide !== exp_iv ||
          (exp_rv && bus.imem_req_addr !== m_pc)) begin
         fails++;
         $display("FAIL ctrl cyc=%0d got rv=%b fl=%b iv=%b addr=%h want rv=%b fl=%b iv=%b addr=%h",
                  cyc, bus.imem_req_valid, bus.flushing, bus.instr_valide, bus.imem_req_addr,
                  exp_rv, exp_flush, exp_iv, m_pc);
      end
      if (exp_iv) begin
         tests++;
         if (bus.instruction !== fifo[0].word || bus.instr_pc !== fifo[0].pc) begin
            fails++;
            $display("FAIL head cyc=%0d got pc=%h insn=%h want pc=%h insn=%h",
                     cyc, bus.instr_pc, bus.instruction, fifo[0].pc, fifo[0].word);
         end
      end
      rsp   = memq.size() != 0 && memq[0].due <= cyc;
      rdata = rsp ? memq[0].addr ^ key : $urandom;
      acc   = exp_rv && ready;
      redir = rmode == 1 || (rmode == 2 && rsp && acc);
      bus.imem_req_ready = ready;
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = rdata;
      bus.ok_i           = ok;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      @(posedge clk);
      if (exp_iv && ok) begin
         pop_log.push_back(bus.instr_pc);
         void'(fifo.pop_front());
      end
      if (rsp) begin
         mq = memq.pop_front();
         t  = tags.pop_front();
         if (!t.stale && !redir) begin
            e.pc   = t.pc;
            e.word = rdata;
            fifo.push_back(e);
         end
      end
      if (acc) begin
         acc_log.push_back(bus.imem_req_addr);
         mq.addr = m_pc;
         mq.due  = cyc + int'($urandom_range(lat_max, lat_min));
         memq.push_back(mq);
         t.pc    = m_pc;
         t.stale = redir;
         tags.push_back(t);
         m_pc    = m_pc + 32'd4;
      end
      if (redir) begin
         foreach (tags[i]) tags[i].stale = 1'b1;
         fifo.delete();
         m_pc = rpc & ~32'h3;
         if (rsp && acc) ev_collide = 1'b1;
      end
      m_boot = 1'b0;
      cyc++;
      @(negedge clk);
   endtask

   // Hold reset for one edge; memory shares the reset so its queue is emptied too.
   task automatic apply_reset();
      rst_n = 1'b1;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.ok_i           = 1'b0;
      bus.redirect_valid = 1'b0;
      memq.delete();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic release_reset();
      rst_n = 1'b0;
      tags.delete();
      fifo.delete();
      memq.delete();
      acc_log.delete();
      pop_log.delete();
      m_pc       = START;
      m_boot     = 1'b1;
      ev_collide = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      tests++;
      if ({bus.imem_req_valid, bus.imem_req_addr, bus.instr_valide, bus.instruction, bus.instr_pc, bus.flushing}
          !== {1'b0, START, 1'b0, 32'h0, 32'h0, 1'b0}) begin
         fails++;
         $display("FAIL reset_vals got rv=%b addr=%h iv=%b insn=%h pc=%h fl=%b want 0 %h 0 0 0 0",
                  bus.imem_req_valid, bus.imem_req_addr, bus.instr_valide, bus.instruction, bus.instr_pc,
                  bus.flushing, START);
      end
      release_reset();
      lat_min = 1; lat_max = 1; key = 32'h0;
      step(1'b1, 1'b1, 0, 32'h0);
      tests++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== START) begin
         fails++;
         $display("FAIL first_req got rv=%b addr=%h want rv=1 addr=%h", bus.imem_req_valid, bus.imem_req_addr, START);
      end
      repeat (3) step(1'b1, 1'b1, 0, 32'h0);
   endtask

   task automatic test_stream();
      apply_reset();
      release_reset();
      lat_min = 1; lat_max = 1; key = 32'h0;
      repeat (40) step(1'b1, 1'b1, 0, 32'h0);
      tests++;
      if (pop_log.size() < 20) begin
         fails++;
         $display("FAIL stream_count got %0d want >=20", pop_log.size());
      end
      foreach (acc_log[i]) begin
         tests++;
         if (acc_log[i] !== 32'(4 * i)) begin
            fails++;
            $display("FAIL stream_req[%0d] got %h want %h", i, acc_log[i], 32'(4 * i));
         end
      end
      foreach (pop_log[i]) begin
         tests++;
         if (pop_log[i] !== 32'(4 * i)) begin
            fails++;
            $display("FAIL stream_pc[%0d] got %h want %h", i, pop_log[i], 32'(4 * i));
         end
      end
   endtask

   task automatic test_backpressure();
      int n0, n1;
      apply_reset();
      release_reset();
      lat_min = 1; lat_max = 1; key = $urandom;
      repeat (4) step(1'b1, 1'b1, 0, 32'h0);
      n0 = acc_log.size();
      repeat (6) step(1'b1, 1'b0, 0, 32'h0);
      tests++;
      if (acc_log.size() - n0 > 2) begin
         fails++;
         $display("FAIL bp_issued got %0d want <=2", acc_log.size() - n0);
      end
      tests++;
      if (bus.imem_req_valid !== 1'b0 || bus.instr_valide !== 1'b1) begin
         fails++;
         $display("FAIL bp_stall got rv=%b iv=%b want rv=0 iv=1", bus.imem_req_valid, bus.instr_valide);
      end
      n0 = acc_log.size();
      n1 = pop_log.size();
      repeat (12) step(1'b1, 1'b1, 0, 32'h0);
      tests++;
      if (pop_log.size() < n1 + 2 || acc_log.size() <= n0) begin
         fails++;
         $display("FAIL bp_resume got pops=%0d reqs=%0d want pops>=2 reqs>=1", pop_log.size() - n1, acc_log.size() - n0);
      end else begin
         tests++;
         if (pop_log[n1 + 1] !== pop_log[n1] + 32'd4) begin
            fails++;
            $display("FAIL bp_order got %h want %h", pop_log[n1 + 1], pop_log[n1] + 32'd4);
         end
      end
   endtask

   task automatic test_redirect_flush();
      int  n, k;
      bit  seen;
      apply_reset();
      release_reset();
      lat_min = 4; lat_max = 4; key = $urandom;
      k = 0;
      while (tags.size() != 2 && k < 20) begin
         step(1'b1, 1'b1, 0, 32'h0);
         k++;
      end
      tests++;
      if (tags.size() != 2) begin
         fails++;
         $display("FAIL rf_setup got %0d outstanding want 2", tags.size());
      end
      step(1'b1, 1'b1, 1, 32'h100);
      n = pop_log.size();
      seen = 1'b0;
      k = 0;
      while (pop_log.size() == n && k < 30) begin
         if (bus.flushing === 1'b1) seen = 1'b1;
         step(1'b1, 1'b1, 0, 32'h0);
         k++;
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL rf_flushing got 0 want 1");
      end
      tests++;
      if (pop_log.size() == n) begin
         fails++;
         $display("FAIL rf_timeout got no instruction want pc 00000100");
      end else if (pop_log[n] !== 32'h100) begin
         fails++;
         $display("FAIL rf_first_pc got %h want 00000100", pop_log[n]);
      end
   endtask

   task automatic test_redirect_collide();
      int k;
      apply_reset();
      release_reset();
      lat_min = 1; lat_max = 2; key = $urandom;
      k = 0;
      while (!ev_collide && k < 300) begin
         step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 2, $urandom);
         k++;
      end
      tests++;
      if (!ev_collide) begin
         fails++;
         $display("FAIL collide_timeout got no rsp+accept cycle want one");
      end else begin
         tests++;
         if (bus.flushing !== 1'b1 || bus.instr_valide !== 1'b0) begin
            fails++;
            $display("FAIL collide_after got fl=%b iv=%b want fl=1 iv=0", bus.flushing, bus.instr_valide);
         end
      end
      repeat (20) step(1'b1, 1'b1, 0, 32'h0);
   endtask

   task automatic test_wrap();
      apply_reset();
      release_reset();
      lat_min = 1; lat_max = 1; key = $urandom;
      step(1'b1, 1'b1, 1, 32'hFFFF_FFFE);
      repeat (8) step(1'b1, 1'b1, 0, 32'h0);
      tests++;
      if (acc_log.size() < 2 || acc_log[0] !== 32'hFFFF_FFFC || acc_log[1] !== 32'h0) begin
         fails++;
         $display("FAIL wrap_req got %0d reqs first=%h,%h want fffffffc,00000000", acc_log.size(),
                  acc_log.size() > 0 ? acc_log[0] : 32'hx, acc_log.size() > 1 ? acc_log[1] : 32'hx);
      end
      tests++;
      if (pop_log.size() < 2 || pop_log[0] !== 32'hFFFF_FFFC || pop_log[1] !== 32'h0) begin
         fails++;
         $display("FAIL wrap_pc got %0d pops want fffffffc then 00000000", pop_log.size());
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      release_reset();
      lat_min = 3; lat_max = 3; key = $urandom;
      repeat (3) step(1'b1, 1'b0, 0, 32'h0);
      tests++;
      if (tags.size() != 2) begin
         fails++;
         $display("FAIL rm_setup got %0d outstanding want 2", tags.size());
      end
      repeat (3) step(1'b1, 1'b0, 0, 32'h0);
      apply_reset();
      tests++;
      if ({bus.imem_req_valid, bus.imem_req_addr, bus.instr_valide, bus.instruction, bus.instr_pc, bus.flushing}
          !== {1'b0, START, 1'b0, 32'h0, 32'h0, 1'b0}) begin
         fails++;
         $display("FAIL rm_vals got rv=%b addr=%h iv=%b insn=%h pc=%h fl=%b want 0 %h 0 0 0 0",
                  bus.imem_req_valid, bus.imem_req_addr, bus.instr_valide, bus.instruction, bus.instr_pc,
                  bus.flushing, START);
      end
      release_reset();
      repeat (3) step(1'b1, 1'b1, 0, 32'h0);
      tests++;
      if (acc_log.size() == 0 || acc_log[0] !== START) begin
         fails++;
         $display("FAIL rm_restart got %0d reqs want first at %h", acc_log.size(), START);
      end
   endtask

   task automatic test_random();
      apply_reset();
      release_reset();
      lat_min = 1; lat_max = 4; key = $urandom;
      repeat (3000) step(1'($urandom_range(99, 0) < 70), 1'($urandom_range(99, 0) < 70),
                         int'($urandom_range(99, 0) < 4), $urandom);
   endtask

   initial begin
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      bus.ok_i           = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_flush();
      test_redirect_collide();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end
endmodule
